// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 register ids, data width and instruction codes
package y86_pkg;

    localparam int DATA_W = 64;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RAX = 4'd0;
    localparam logic [3:0] RCX = 4'd1;
    localparam logic [3:0] RDX = 4'd2;
    localparam logic [3:0] RBX = 4'd3;
    localparam logic [3:0] RSP = 4'd4;
    localparam logic [3:0] RBP = 4'd5;
    localparam logic [3:0] RSI = 4'd6;
    localparam logic [3:0] RDI = 4'd7;
    localparam logic [3:0] R8  = 4'd8;
    localparam logic [3:0] R9  = 4'd9;
    localparam logic [3:0] R10 = 4'd10;
    localparam logic [3:0] R11 = 4'd11;
    localparam logic [3:0] R12 = 4'd12;
    localparam logic [3:0] R13 = 4'd13;
    localparam logic [3:0] R14 = 4'd14;

    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IRMOVQ  = 4'h3,
        RMMOVQ  = 4'h4,
        MRMOVQ  = 4'h5,
        OPQ     = 4'h6,
        JXX     = 4'h7,
        CALL    = 4'h8,
        RET     = 4'h9,
        PUSHQ   = 4'hA,
        POPQ    = 4'hB
    } icode_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write counters with saturation and sticky error flags
module regfile_scoreboard #(
    parameter int ADDR_W = 4,
    parameter int NREGS = 15,
    parameter logic [ADDR_W-1:0] RNONE = '1,
    parameter int PEND_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       dst_e,
    input  logic [ADDR_W-1:0]       dst_m,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_dst_e,
    input  logic [ADDR_W-1:0]       iss_dst_m,
    output logic [NREGS*PEND_W-1:0] cnt,
    output logic                    err_ovf,
    output logic                    err_unf
);
    localparam int NW = PEND_W + 2;
    localparam logic [NW-1:0] CNT_MAX = NW'((1 << PEND_W) - 1);

    logic [PEND_W-1:0] cnt_q [NREGS];
    logic [PEND_W-1:0] cnt_d [NREGS];
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              de_ok, dm_ok, ie_ok, im_ok;

    assign de_ok = (dst_e != RNONE) && (int'(dst_e) < NREGS);
    assign dm_ok = (dst_m != RNONE) && (int'(dst_m) < NREGS);
    assign ie_ok = iss_valid && (iss_dst_e != RNONE) && (int'(iss_dst_e) < NREGS);
    assign im_ok = iss_valid && (iss_dst_m != RNONE) && (int'(iss_dst_m) < NREGS);

    // Issue and write-back net together; underflow is judged against the old count only.
    always_comb begin : netting
        logic [NW-1:0] inc, dec, sum, cur;
        ovf_d = ovf_q;
        unf_d = unf_q;
        inc = '0;
        dec = '0;
        sum = '0;
        cur = '0;
        for (int r = 0; r < NREGS; r++) begin
            inc = '0;
            dec = '0;
            cur = NW'(cnt_q[r]);
            if (ie_ok && iss_dst_e == ADDR_W'(r)) inc = inc + NW'(1);
            if (im_ok && iss_dst_m == ADDR_W'(r)) inc = inc + NW'(1);
            if (de_ok && dst_e == ADDR_W'(r)) dec = dec + NW'(1);
            if (dm_ok && dst_m == ADDR_W'(r)) dec = dec + NW'(1);
            if (cur < dec) unf_d = 1'b1;
            sum = cur + inc;
            if (sum < dec) begin
                cnt_d[r] = '0;
            end else if (sum - dec > CNT_MAX) begin
                cnt_d[r] = CNT_MAX[PEND_W-1:0];
                ovf_d = 1'b1;
            end else begin
                sum = sum - dec;
                cnt_d[r] = sum[PEND_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_comb begin
        cnt = '0;
        for (int r = 0; r < NREGS; r++) cnt[r*PEND_W +: PEND_W] = cnt_q[r];
    end

    assign err_ovf = ovf_q;
    assign err_unf = unf_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - decode-stage register file with two read ports, two write-backs, bypass and scoreboard
module regfile_sb #(
    parameter int DATA_W = y86_pkg::DATA_W,
    parameter int ADDR_W = 4,
    parameter int NREGS = 15,
    parameter logic [ADDR_W-1:0] RNONE = ADDR_W'(y86_pkg::RNONE),
    parameter int PEND_W = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              rdyA,
    output logic              rdyB,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dstE,
    input  logic [ADDR_W-1:0] iss_dstM,
    output logic              err_ovf,
    output logic              err_unf
);
    import y86_pkg::*;

    localparam int NW = PEND_W + 2;

    logic [DATA_W-1:0]       regs_q [NREGS];
    logic [DATA_W-1:0]       regs_d [NREGS];
    logic [NREGS*PEND_W-1:0] cnt;
    logic                    wr_e_ok, wr_m_ok;
    logic [ADDR_W-1:0]       rd_src [2];
    logic [DATA_W-1:0]       rd_val [2];
    logic                    rd_rdy [2];

    assign wr_e_ok = (dstE != RNONE) && (int'(dstE) < NREGS);
    assign wr_m_ok = (dstM != RNONE) && (int'(dstM) < NREGS);

    // M is applied last so it wins when both ports target the same register.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
            if (wr_e_ok && dstE == ADDR_W'(r)) regs_d[r] = valE;
            if (wr_m_ok && dstM == ADDR_W'(r)) regs_d[r] = valM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS),
        .RNONE  (RNONE),
        .PEND_W (PEND_W)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .dst_e     (dstE),
        .dst_m     (dstM),
        .iss_valid (iss_valid),
        .iss_dst_e (iss_dstE),
        .iss_dst_m (iss_dstM),
        .cnt       (cnt),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf)
    );

    assign rd_src[0] = srcA;
    assign rd_src[1] = srcB;

    // A pending register is still ready if every outstanding write lands this cycle via bypass.
    always_comb begin : read_ports
        logic [DATA_W-1:0] stored;
        logic [PEND_W-1:0] pend;
        logic [NW-1:0]     hits;
        stored = '0;
        pend = '0;
        hits = '0;
        for (int p = 0; p < 2; p++) begin
            rd_val[p] = '0;
            rd_rdy[p] = 1'b1;
            stored = '0;
            pend = '0;
            hits = '0;
            if (rd_src[p] != RNONE && int'(rd_src[p]) < NREGS) begin
                for (int r = 0; r < NREGS; r++) begin
                    if (rd_src[p] == ADDR_W'(r)) begin
                        stored = regs_q[r];
                        pend = cnt[r*PEND_W +: PEND_W];
                    end
                end
                if (wr_e_ok && dstE == rd_src[p]) hits = hits + NW'(1);
                if (wr_m_ok && dstM == rd_src[p]) hits = hits + NW'(1);
                rd_val[p] = stored;
                if (BYPASS && wr_m_ok && dstM == rd_src[p]) begin
                    rd_val[p] = valM;
                end else if (BYPASS && wr_e_ok && dstE == rd_src[p]) begin
                    rd_val[p] = valE;
                end
                rd_rdy[p] = (pend == '0) || (BYPASS && NW'(pend) == hits);
            end
        end
    end

    assign valA = rd_val[0];
    assign valB = rd_val[1];
    assign rdyA = rd_rdy[0];
    assign rdyB = rd_rdy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb, bypass and non-bypass builds
module tb_regfile_sb;
    import y86_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  srcA, srcB, dstE, dstM, iss_dstE, iss_dstM;
    logic [63:0] valE, valM;
    logic        iss_valid;
    logic [63:0] valA, valB, nb_valA, nb_valB;
    logic        rdyA, rdyB, nb_rdyA, nb_rdyB;
    logic        err_ovf, err_unf, nb_err_ovf, nb_err_unf;

    int tests_run = 0;
    int tests_failed = 0;

    regfile_sb #(.BYPASS(1'b1)) u_dut (
        .clk(clk), .reset(reset), .srcA(srcA), .srcB(srcB),
        .valA(valA), .valB(valB), .rdyA(rdyA), .rdyB(rdyB),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .iss_valid(iss_valid), .iss_dstE(iss_dstE), .iss_dstM(iss_dstM),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    regfile_sb #(.BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .reset(reset), .srcA(srcA), .srcB(srcB),
        .valA(nb_valA), .valB(nb_valB), .rdyA(nb_rdyA), .rdyB(nb_rdyB),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .iss_valid(iss_valid), .iss_dstE(iss_dstE), .iss_dstM(iss_dstM),
        .err_ovf(nb_err_ovf), .err_unf(nb_err_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dstE = RNONE; dstM = RNONE; valE = '0; valM = '0;
        iss_valid = 1'b0; iss_dstE = RNONE; iss_dstM = RNONE;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        srcA = RAX; srcB = RBX;
        #1;
        tests_run++; if (valA !== 64'd0) begin tests_failed++; $display("FAIL reset_valA got %0d exp 0", valA); end
        tests_run++; if (valB !== 64'd0) begin tests_failed++; $display("FAIL reset_valB got %0d exp 0", valB); end
        tests_run++; if (rdyA !== 1'b1) begin tests_failed++; $display("FAIL reset_rdyA got %b exp 1", rdyA); end
        tests_run++; if (rdyB !== 1'b1) begin tests_failed++; $display("FAIL reset_rdyB got %b exp 1", rdyB); end
        tests_run++; if (err_ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b exp 0", err_ovf); end
        tests_run++; if (err_unf !== 1'b0) begin tests_failed++; $display("FAIL reset_unf got %b exp 0", err_unf); end
    endtask

    task automatic test_write_read();
        dstE = RBX; valE = 64'd525;
        tick();
        dstE = RAX; valE = 64'd300;
        tick();
        idle();
        srcA = RAX; srcB = RBX;
        #1;
        tests_run++; if (valA !== 64'd300) begin tests_failed++; $display("FAIL wr_valA got %0d exp 300", valA); end
        tests_run++; if (valB !== 64'd525) begin tests_failed++; $display("FAIL wr_valB got %0d exp 525", valB); end
        tests_run++; if (nb_valA !== 64'd300) begin tests_failed++; $display("FAIL wr_nb_valA got %0d exp 300", nb_valA); end
        tests_run++; if (nb_valB !== 64'd525) begin tests_failed++; $display("FAIL wr_nb_valB got %0d exp 525", nb_valB); end
        tests_run++; if (err_unf !== 1'b1) begin tests_failed++; $display("FAIL wr_unf got %b exp 1", err_unf); end
    endtask

    task automatic test_bypass();
        dstE = RDX; valE = 64'd251; srcA = RDX;
        #1;
        tests_run++; if (valA !== 64'd251) begin tests_failed++; $display("FAIL byp_valA got %0d exp 251", valA); end
        tests_run++; if (nb_valA !== 64'd0) begin tests_failed++; $display("FAIL byp_nb_before got %0d exp 0", nb_valA); end
        tick();
        idle();
        #1;
        tests_run++; if (nb_valA !== 64'd251) begin tests_failed++; $display("FAIL byp_nb_after got %0d exp 251", nb_valA); end
    endtask

    task automatic test_conflict();
        dstE = RSP; valE = 64'd999; dstM = RSP; valM = 64'd777; srcA = RSP;
        #1;
        tests_run++; if (valA !== 64'd777) begin tests_failed++; $display("FAIL conf_bypass got %0d exp 777", valA); end
        tick();
        idle();
        #1;
        tests_run++; if (valA !== 64'd777) begin tests_failed++; $display("FAIL conf_valA got %0d exp 777", valA); end
        tests_run++; if (nb_valA !== 64'd777) begin tests_failed++; $display("FAIL conf_nb_valA got %0d exp 777", nb_valA); end
    endtask

    task automatic test_load_use();
        srcA = RAX;
        iss_valid = 1'b1; iss_dstM = RAX;
        #1;
        tests_run++; if (rdyA !== 1'b1) begin tests_failed++; $display("FAIL lu_same_cycle got %b exp 1", rdyA); end
        tick();
        idle();
        #1;
        tests_run++; if (rdyA !== 1'b0) begin tests_failed++; $display("FAIL lu_pending got %b exp 0", rdyA); end
        tests_run++; if (nb_rdyA !== 1'b0) begin tests_failed++; $display("FAIL lu_nb_pending got %b exp 0", nb_rdyA); end
        dstM = RAX; valM = 64'd42;
        #1;
        tests_run++; if (rdyA !== 1'b1) begin tests_failed++; $display("FAIL lu_wb_rdy got %b exp 1", rdyA); end
        tests_run++; if (valA !== 64'd42) begin tests_failed++; $display("FAIL lu_wb_val got %0d exp 42", valA); end
        tests_run++; if (nb_rdyA !== 1'b0) begin tests_failed++; $display("FAIL lu_nb_wb_rdy got %b exp 0", nb_rdyA); end
        tests_run++; if (nb_valA !== 64'd300) begin tests_failed++; $display("FAIL lu_nb_wb_val got %0d exp 300", nb_valA); end
        tick();
        idle();
        #1;
        tests_run++; if (rdyA !== 1'b1) begin tests_failed++; $display("FAIL lu_after_rdy got %b exp 1", rdyA); end
        tests_run++; if (nb_rdyA !== 1'b1) begin tests_failed++; $display("FAIL lu_nb_after_rdy got %b exp 1", nb_rdyA); end
        tests_run++; if (nb_valA !== 64'd42) begin tests_failed++; $display("FAIL lu_nb_after_val got %0d exp 42", nb_valA); end
    endtask

    task automatic test_overflow();
        do_reset();
        srcA = RCX;
        iss_valid = 1'b1; iss_dstE = RCX;
        repeat (4) tick();
        idle();
        #1;
        tests_run++; if (err_ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b exp 1", err_ovf); end
        tests_run++; if (err_unf !== 1'b0) begin tests_failed++; $display("FAIL ovf_unf got %b exp 0", err_unf); end
        tests_run++; if (rdyA !== 1'b0) begin tests_failed++; $display("FAIL ovf_rdy got %b exp 0", rdyA); end
        dstE = RCX; valE = 64'd5;
        #1;
        tests_run++; if (rdyA !== 1'b0) begin tests_failed++; $display("FAIL ovf_cnt3_rdy got %b exp 0", rdyA); end
        tick();
        dstE = RCX; valE = 64'd5; dstM = RCX; valM = 64'd6;
        #1;
        tests_run++; if (rdyA !== 1'b1) begin tests_failed++; $display("FAIL ovf_cnt2_rdy got %b exp 1", rdyA); end
        tests_run++; if (nb_rdyA !== 1'b0) begin tests_failed++; $display("FAIL ovf_nb_cnt2_rdy got %b exp 0", nb_rdyA); end
        tests_run++; if (valA !== 64'd6) begin tests_failed++; $display("FAIL ovf_valA got %0d exp 6", valA); end
        tick();
        idle();
        #1;
        tests_run++; if (nb_rdyA !== 1'b1) begin tests_failed++; $display("FAIL ovf_drained_rdy got %b exp 1", nb_rdyA); end
        tests_run++; if (err_unf !== 1'b0) begin tests_failed++; $display("FAIL ovf_drained_unf got %b exp 0", err_unf); end
        tests_run++; if (err_ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got %b exp 1", err_ovf); end
    endtask

    task automatic test_underflow();
        do_reset();
        #1;
        tests_run++; if (err_ovf !== 1'b0) begin tests_failed++; $display("FAIL unf_ovf_cleared got %b exp 0", err_ovf); end
        dstE = RCX; valE = 64'd77;
        tick();
        idle();
        srcA = RCX;
        #1;
        tests_run++; if (err_unf !== 1'b1) begin tests_failed++; $display("FAIL unf_flag got %b exp 1", err_unf); end
        tests_run++; if (valA !== 64'd77) begin tests_failed++; $display("FAIL unf_valA got %0d exp 77", valA); end
        tests_run++; if (rdyA !== 1'b1) begin tests_failed++; $display("FAIL unf_rdy got %b exp 1", rdyA); end
    endtask

    task automatic test_reset_override();
        reset = 1'b1;
        dstE = RCX; valE = 64'd55;
        iss_valid = 1'b1; iss_dstE = RDX;
        tick();
        reset = 1'b0;
        idle();
        srcA = RCX; srcB = RDX;
        #1;
        tests_run++; if (valA !== 64'd0) begin tests_failed++; $display("FAIL rst_ovr_valA got %0d exp 0", valA); end
        tests_run++; if (nb_valA !== 64'd0) begin tests_failed++; $display("FAIL rst_ovr_nb_valA got %0d exp 0", nb_valA); end
        tests_run++; if (rdyB !== 1'b1) begin tests_failed++; $display("FAIL rst_ovr_rdyB got %b exp 1", rdyB); end
        tests_run++; if (err_unf !== 1'b0) begin tests_failed++; $display("FAIL rst_ovr_unf got %b exp 0", err_unf); end
    endtask

    task automatic test_invalid();
        srcA = RNONE;
        dstE = RNONE; valE = 64'd123; dstM = RNONE; valM = 64'd9;
        iss_valid = 1'b1; iss_dstE = RNONE; iss_dstM = RNONE;
        #1;
        tests_run++; if (valA !== 64'd0) begin tests_failed++; $display("FAIL inv_valA got %0d exp 0", valA); end
        tests_run++; if (rdyA !== 1'b1) begin tests_failed++; $display("FAIL inv_rdyA got %b exp 1", rdyA); end
        tick();
        idle();
        #1;
        tests_run++; if (err_unf !== 1'b0) begin tests_failed++; $display("FAIL inv_unf got %b exp 0", err_unf); end
        tests_run++; if (err_ovf !== 1'b0) begin tests_failed++; $display("FAIL inv_ovf got %b exp 0", err_ovf); end
    endtask

    initial begin
        reset = 1'b0;
        srcA = RNONE; srcB = RNONE;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_conflict();
        test_load_use();
        test_overflow();
        test_underflow();
        test_reset_override();
        test_invalid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
